// File: rtl/xlr8_pcint_ctrl.sv
// rtl/xlr8_pcint_ctrl.sv - pin-change interrupt control/flag registers with per-port IRQ and optional sleep wake
// Optional wake handshake is built only when XLR8_PCINT_WAKE_EN is defined; otherwise wake_req is tied low.
module xlr8_pcint_ctrl #(
    parameter logic [7:0] PCICR_ADDR = 8'h68,
    parameter logic [7:0] PCIFR_ADDR = 8'h1B,
    parameter int         NUM_PORTS  = 3
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 clken,
    input  logic [5:0]           adr,
    input  logic                 iore,
    input  logic                 iowe,
    input  logic [7:0]           ramadr,
    input  logic                 ramre,
    input  logic                 ramwe,
    input  logic                 dm_sel,
    input  logic [7:0]           dbus_in,
    output logic [7:0]           dbus_out,
    output logic                 io_out_en,
    input  logic [NUM_PORTS-1:0] pcifr_set,
    output logic [NUM_PORTS-1:0] pcint_irq,
    input  logic [NUM_PORTS-1:0] pcint_ack,
    output logic                 wake_req,
    input  logic                 wake_ack
);

    // Registers at or above 0x60 live in extended data memory, below that in I/O space
    localparam bit CR_IN_DM = (PCICR_ADDR >= 8'h60);
    localparam bit FR_IN_DM = (PCIFR_ADDR >= 8'h60);

    logic                 cr_hit;
    logic                 fr_hit;
    logic                 cr_re;
    logic                 cr_we;
    logic                 fr_re;
    logic                 fr_we;
    logic [NUM_PORTS-1:0] pcicr;
    logic [NUM_PORTS-1:0] pcifr;
    logic [NUM_PORTS-1:0] fr_clr;
    logic [7:0]           cr_ext;
    logic [7:0]           fr_ext;
    logic [7:0]           unused_dbus;

    // Only the low NUM_PORTS data bits are meaningful; the rest are intentionally dropped
    assign unused_dbus = dbus_in;

    // Address decode and read/write strobes for both registers
    always_comb begin
        cr_hit = CR_IN_DM ? (dm_sel && (ramadr == PCICR_ADDR)) : (adr == PCICR_ADDR[5:0]);
        fr_hit = FR_IN_DM ? (dm_sel && (ramadr == PCIFR_ADDR)) : (adr == PCIFR_ADDR[5:0]);
        cr_re  = cr_hit && (CR_IN_DM ? ramre : iore);
        cr_we  = cr_hit && (CR_IN_DM ? ramwe : iowe);
        fr_re  = fr_hit && (FR_IN_DM ? ramre : iore);
        fr_we  = fr_hit && (FR_IN_DM ? ramwe : iowe);
    end

    // Flag clear sources: write-one-to-clear from software (clken gated) and vector acknowledge (ungated)
    always_comb begin
        fr_clr = pcint_ack;
        if (fr_we && clken) begin
            fr_clr = fr_clr | dbus_in[NUM_PORTS-1:0];
        end
    end

    // Enable register: software writable only while the core clock is enabled
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pcicr <= '0;
        end else if (cr_we && clken) begin
            pcicr <= dbus_in[NUM_PORTS-1:0];
        end
    end

    // Flag register: set wins over any coincident clear so no pin change is ever lost
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pcifr <= '0;
        end else begin
            pcifr <= (pcifr & ~fr_clr) | pcifr_set;
        end
    end

    assign pcint_irq = pcifr & pcicr;

    // Zero-extend both registers to the bus width, unused upper bits read as zero
    always_comb begin
        cr_ext                = '0;
        fr_ext                = '0;
        cr_ext[NUM_PORTS-1:0] = pcicr;
        fr_ext[NUM_PORTS-1:0] = pcifr;
    end

    // Read mux: OR of whichever registers are being read, zero when neither
    always_comb begin
        dbus_out  = (cr_re ? cr_ext : 8'h00) | (fr_re ? fr_ext : 8'h00);
        io_out_en = cr_re || fr_re;
    end

`ifdef XLR8_PCINT_WAKE_EN
    // Wake request latches on any enabled pin change and drops on acknowledge, new change winning
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wake_req <= 1'b0;
        end else if (|(pcifr_set & pcicr)) begin
            wake_req <= 1'b1;
        end else if (wake_ack) begin
            wake_req <= 1'b0;
        end
    end
`else
    logic unused_wake_ack;
    assign unused_wake_ack = wake_ack;
    assign wake_req        = 1'b0;
`endif

endmodule
